ysyx_23060236_rd_arbiter: RTL and testbench

- Read-channel arbiter and address router sharing read slaves between the instruction-fetch and load-store units.
- Two AXI-lite-style read masters: m0 is the IFU, m1 is the LSU.
- Two read slaves: s0 is the CLINT (mtime), s1 is the external memory/SoC bus.
- One transaction in flight at a time, round-robin grant, registered decision.

---
 rtl/ysyx_23060236_rd_arbiter.sv | 153 +++++++++++++++
 tb/tb_ysyx_23060236_rd_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_rd_arbiter.sv
// Read-channel arbiter between the IFU (m0) and LSU (m1), routing a single
// in-flight read to either the CLINT (s0) or the external bus (s1).
module ysyx_23060236_rd_arbiter #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_SIZE = 32'h0001_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] s0_araddr,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    output logic [31:0] s1_araddr,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    input  logic        s1_rvalid,
    output logic        s1_rready
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   target_q, target_d;
    logic   last_grant_q, last_grant_d;

    logic [31:0] req_addr;
    logic        ar_rdy;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    // 33-bit window compare so BASE+SIZE cannot wrap past 2^32.
    function automatic logic decode_target(input logic [31:0] addr);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, CLINT_BASE};
        hi = lo + {1'b0, CLINT_SIZE};
        return !((a >= lo) && (a < hi));
    endfunction

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        target_d     = target_q;
        last_grant_d = last_grant_q;
        req_addr     = 32'd0;
        ar_rdy       = 1'b0;
        r_valid      = 1'b0;
        r_ready      = 1'b0;
        r_data       = 32'd0;
        r_resp       = 2'd0;
        m0_arready   = 1'b0;
        m0_rdata     = 32'd0;
        m0_rresp     = 2'd0;
        m0_rvalid    = 1'b0;
        m1_arready   = 1'b0;
        m1_rdata     = 32'd0;
        m1_rresp     = 2'd0;
        m1_rvalid    = 1'b0;
        s0_araddr    = 32'd0;
        s0_arvalid   = 1'b0;
        s0_rready    = 1'b0;
        s1_araddr    = 32'd0;
        s1_arvalid   = 1'b0;
        s1_rready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    grant_d  = (m0_arvalid && m1_arvalid) ? ~last_grant_q : m1_arvalid;
                    target_d = decode_target(grant_d ? m1_araddr : m0_araddr);
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                req_addr = grant_q ? m1_araddr : m0_araddr;
                if (target_q) begin
                    s1_arvalid = 1'b1;
                    s1_araddr  = req_addr;
                    ar_rdy     = s1_arready;
                end else begin
                    s0_arvalid = 1'b1;
                    s0_araddr  = req_addr;
                    ar_rdy     = s0_arready;
                end
                if (grant_q) m1_arready = ar_rdy;
                else         m0_arready = ar_rdy;
                if (ar_rdy) state_d = RESP;
            end
            RESP: begin
                r_valid = target_q ? s1_rvalid : s0_rvalid;
                r_data  = target_q ? s1_rdata  : s0_rdata;
                r_resp  = target_q ? s1_rresp  : s0_rresp;
                r_ready = grant_q  ? m1_rready : m0_rready;
                if (target_q) s1_rready = r_ready;
                else          s0_rready = r_ready;
                if (grant_q) begin
                    m1_rvalid = r_valid;
                    m1_rdata  = r_data;
                    m1_rresp  = r_resp;
                end else begin
                    m0_rvalid = r_valid;
                    m0_rdata  = r_data;
                    m0_rresp  = r_resp;
                end
                if (r_valid && r_ready) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to m1 so that m0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            target_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            target_q     <= target_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// Directed bench for the IFU/LSU read arbiter: routing, round-robin,
// back-pressure and reset-in-flight behaviour.
module tb_ysyx_23060236_rd_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] m_araddr [2];
    logic [1:0]  m_arvalid;
    logic [1:0]  m_arready;
    logic [31:0] m_rdata [2];
    logic [1:0]  m_rresp [2];
    logic [1:0]  m_rvalid;
    logic [1:0]  m_rready;
    logic [31:0] s_araddr [2];
    logic [1:0]  s_arvalid;
    logic [1:0]  s_arready;
    logic [31:0] s_rdata [2];
    logic [1:0]  s_rresp [2];
    logic [1:0]  s_rvalid;
    logic [1:0]  s_rready;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_23060236_rd_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .m0_araddr  (m_araddr[0]),
        .m0_arvalid (m_arvalid[0]),
        .m0_arready (m_arready[0]),
        .m0_rdata   (m_rdata[0]),
        .m0_rresp   (m_rresp[0]),
        .m0_rvalid  (m_rvalid[0]),
        .m0_rready  (m_rready[0]),
        .m1_araddr  (m_araddr[1]),
        .m1_arvalid (m_arvalid[1]),
        .m1_arready (m_arready[1]),
        .m1_rdata   (m_rdata[1]),
        .m1_rresp   (m_rresp[1]),
        .m1_rvalid  (m_rvalid[1]),
        .m1_rready  (m_rready[1]),
        .s0_araddr  (s_araddr[0]),
        .s0_arvalid (s_arvalid[0]),
        .s0_arready (s_arready[0]),
        .s0_rdata   (s_rdata[0]),
        .s0_rresp   (s_rresp[0]),
        .s0_rvalid  (s_rvalid[0]),
        .s0_rready  (s_rready[0]),
        .s1_araddr  (s_araddr[1]),
        .s1_arvalid (s_arvalid[1]),
        .s1_arready (s_arready[1]),
        .s1_rdata   (s_rdata[1]),
        .s1_rresp   (s_rresp[1]),
        .s1_rvalid  (s_rvalid[1]),
        .s1_rready  (s_rready[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_araddr[i] = 32'd0;
            s_rdata[i]  = 32'd0;
            s_rresp[i]  = 2'd0;
        end
        m_arvalid = 2'b00;
        m_rready  = 2'b00;
        s_arready = 2'b00;
        s_rvalid  = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic quiet(input string tag);
        check({tag, ".s0_arvalid"}, 32'(s_arvalid[0]), 0);
        check({tag, ".s1_arvalid"}, 32'(s_arvalid[1]), 0);
        check({tag, ".m0_arready"}, 32'(m_arready[0]), 0);
        check({tag, ".m1_arready"}, 32'(m_arready[1]), 0);
        check({tag, ".m0_rvalid"},  32'(m_rvalid[0]), 0);
        check({tag, ".m1_rvalid"},  32'(m_rvalid[1]), 0);
        check({tag, ".s0_rready"},  32'(s_rready[0]), 0);
        check({tag, ".s1_rready"},  32'(s_rready[1]), 0);
    endtask

    // Single read from master m expected at slave t, slave ready in one cycle.
    task automatic txn(input int m, input logic [31:0] addr, input int t,
                       input logic [31:0] data, input logic [1:0] resp, input string tag);
        m_arvalid[m] = 1'b1;
        m_araddr[m]  = addr;
        #1;
        check({tag, ".idle_arready"}, 32'(m_arready[m]), 0);
        tick();
        check({tag, ".arvalid"},       32'(s_arvalid[t]), 1);
        check({tag, ".araddr"},        s_araddr[t], addr);
        check({tag, ".other_arvalid"}, 32'(s_arvalid[1-t]), 0);
        check({tag, ".other_araddr"},  s_araddr[1-t], 32'd0);
        s_arready[t] = 1'b1;
        #1;
        check({tag, ".arready"},       32'(m_arready[m]), 1);
        check({tag, ".other_arready"}, 32'(m_arready[1-m]), 0);
        tick();
        m_arvalid[m] = 1'b0;
        m_araddr[m]  = 32'd0;
        s_arready[t] = 1'b0;
        s_rvalid[t]  = 1'b1;
        s_rdata[t]   = data;
        s_rresp[t]   = resp;
        m_rready[m]  = 1'b1;
        #1;
        check({tag, ".rvalid"},       32'(m_rvalid[m]), 1);
        check({tag, ".rdata"},        m_rdata[m], data);
        check({tag, ".rresp"},        32'(m_rresp[m]), 32'(resp));
        check({tag, ".other_rvalid"}, 32'(m_rvalid[1-m]), 0);
        check({tag, ".other_rdata"},  m_rdata[1-m], 32'd0);
        check({tag, ".rready"},       32'(s_rready[t]), 1);
        check({tag, ".other_rready"}, 32'(s_rready[1-t]), 0);
        tick();
        s_rvalid[t] = 1'b0;
        s_rdata[t]  = 32'd0;
        s_rresp[t]  = 2'd0;
        m_rready[m] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        #1;
        quiet("reset");
        check("reset.s1_araddr", s_araddr[1], 32'd0);
        check("reset.m0_rdata",  m_rdata[0], 32'd0);
        tick();
        reset = 1'b0;

        // m0 read to external memory, slave ready two cycles into ADDR
        m_arvalid[0] = 1'b1;
        m_araddr[0]  = 32'h8000_0000;
        #1;
        check("t1.idle_s1_arvalid", 32'(s_arvalid[1]), 0);
        check("t1.idle_arready",    32'(m_arready[0]), 0);
        tick();
        check("t1.s1_arvalid", 32'(s_arvalid[1]), 1);
        check("t1.s1_araddr",  s_araddr[1], 32'h8000_0000);
        check("t1.m0_arready_wait", 32'(m_arready[0]), 0);
        tick();
        check("t1.s1_arvalid_held", 32'(s_arvalid[1]), 1);
        s_arready[1] = 1'b1;
        #1;
        check("t1.m0_arready", 32'(m_arready[0]), 1);
        check("t1.m1_arready", 32'(m_arready[1]), 0);
        check("t1.s0_arvalid", 32'(s_arvalid[0]), 0);
        tick();
        m_arvalid[0] = 1'b0;
        m_araddr[0]  = 32'd0;
        s_arready[1] = 1'b0;
        s_rvalid[1]  = 1'b1;
        s_rdata[1]   = 32'hdead_beef;
        m_rready[0]  = 1'b1;
        #1;
        check("t1.m0_rvalid", 32'(m_rvalid[0]), 1);
        check("t1.m0_rdata",  m_rdata[0], 32'hdead_beef);
        check("t1.m1_rvalid", 32'(m_rvalid[1]), 0);
        check("t1.m1_rdata",  m_rdata[1], 32'd0);
        check("t1.s1_rready", 32'(s_rready[1]), 1);
        check("t1.s0_rready", 32'(s_rready[0]), 0);
        tick();
        s_rvalid[1] = 1'b0;
        s_rdata[1]  = 32'd0;
        m_rready[0] = 1'b0;
        #1;
        quiet("t1.after");

        txn(1, 32'h0200_0004, 0, 32'h0000_0001, 2'b00, "t2");

        txn(0, 32'h01ff_fffc, 1, 32'h1111_0001, 2'b10, "dec0");
        txn(0, 32'h0200_0000, 0, 32'h1111_0002, 2'b00, "dec1");
        txn(0, 32'h0200_fffc, 0, 32'h1111_0003, 2'b11, "dec2");
        txn(0, 32'h0201_0000, 1, 32'h1111_0004, 2'b00, "dec3");

        // Both masters requesting continuously: strict alternation from m0
        do_reset();
        m_arvalid   = 2'b11;
        m_araddr[0] = 32'h8000_0010;
        m_araddr[1] = 32'h8000_0020;
        for (int k = 0; k < 4; k++) begin
            int e;
            e = k % 2;
            #1;
            check($sformatf("rr%0d.idle_arready", k), 32'(m_arready), 0);
            tick();
            check($sformatf("rr%0d.araddr", k), s_araddr[1], m_araddr[e]);
            s_arready[1] = 1'b1;
            #1;
            check($sformatf("rr%0d.arready", k),       32'(m_arready[e]), 1);
            check($sformatf("rr%0d.other_arready", k), 32'(m_arready[1-e]), 0);
            tick();
            s_arready[1] = 1'b0;
            s_rvalid[1]  = 1'b1;
            s_rdata[1]   = 32'h0000_1000 + k;
            m_rready     = 2'b11;
            #1;
            check($sformatf("rr%0d.rvalid", k),       32'(m_rvalid[e]), 1);
            check($sformatf("rr%0d.rdata", k),        m_rdata[e], 32'h0000_1000 + k);
            check($sformatf("rr%0d.other_rvalid", k), 32'(m_rvalid[1-e]), 0);
            check($sformatf("rr%0d.other_rdata", k),  m_rdata[1-e], 32'd0);
            tick();
            s_rvalid[1] = 1'b0;
            m_rready    = 2'b00;
        end
        clear_inputs();

        // m0 stalls rready while m1 queues a request
        m_arvalid[0] = 1'b1;
        m_araddr[0]  = 32'h8000_0030;
        tick();
        s_arready[1] = 1'b1;
        tick();
        m_arvalid[0] = 1'b0;
        s_arready[1] = 1'b0;
        s_rvalid[1]  = 1'b1;
        s_rdata[1]   = 32'hcafe_0001;
        m_arvalid[1] = 1'b1;
        m_araddr[1]  = 32'h8000_0040;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d.m0_rvalid", k),  32'(m_rvalid[0]), 1);
            check($sformatf("bp%0d.s1_rready", k),  32'(s_rready[1]), 0);
            check($sformatf("bp%0d.m1_arready", k), 32'(m_arready[1]), 0);
            check($sformatf("bp%0d.s1_arvalid", k), 32'(s_arvalid[1]), 0);
            tick();
        end
        m_rready[0] = 1'b1;
        #1;
        check("bp.s1_rready", 32'(s_rready[1]), 1);
        tick();
        s_rvalid[1] = 1'b0;
        m_rready[0] = 1'b0;
        #1;
        check("bp.idle_s1_arvalid", 32'(s_arvalid[1]), 0);
        check("bp.idle_m1_arready", 32'(m_arready[1]), 0);
        tick();
        check("bp.m1_s1_arvalid", 32'(s_arvalid[1]), 1);
        check("bp.m1_s1_araddr",  s_araddr[1], 32'h8000_0040);
        s_arready[1] = 1'b1;
        #1;
        check("bp.m1_arready", 32'(m_arready[1]), 1);
        tick();
        m_arvalid[1] = 1'b0;
        s_arready[1] = 1'b0;
        s_rvalid[1]  = 1'b1;
        s_rdata[1]   = 32'hcafe_0002;
        m_rready[1]  = 1'b1;
        #1;
        check("bp.m1_rdata", m_rdata[1], 32'hcafe_0002);
        tick();
        clear_inputs();

        // m0 wins a completed read, so last grant is m0 before the reset test
        txn(0, 32'h8000_0050, 1, 32'h5555_0001, 2'b00, "pre");
        m_arvalid[0] = 1'b1;
        m_araddr[0]  = 32'h8000_0060;
        tick();
        s_arready[1] = 1'b1;
        tick();
        m_arvalid[0] = 1'b0;
        s_arready[1] = 1'b0;
        s_rvalid[1]  = 1'b1;
        s_rdata[1]   = 32'h7777_0001;
        #1;
        check("rst.pre_m0_rvalid", 32'(m_rvalid[0]), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        quiet("rst.after");
        s_rvalid[1]  = 1'b0;
        m_arvalid    = 2'b11;
        m_araddr[0]  = 32'h8000_0070;
        m_araddr[1]  = 32'h8000_0080;
        tick();
        check("rst.tie_araddr",  s_araddr[1], 32'h8000_0070);
        check("rst.tie_arvalid", 32'(s_arvalid[1]), 1);
        s_arready[1] = 1'b1;
        #1;
        check("rst.tie_m0_arready", 32'(m_arready[0]), 1);
        check("rst.tie_m1_arready", 32'(m_arready[1]), 0);
        tick();
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
